// File: rtl/complex_mult_arbiter_pkg.sv
// Shared definitions for the complex multiplier arbiter.
//   state_t    : arbiter FSM encoding (IDLE=0, ISSUE=1, WAIT_RES=2, DELIVER=3)
//   REQ_IDX_W  : width of a requester index, sized for the largest supported NUM_REQ
//   WDOG_W     : width of the WAIT_RES watchdog counter, sized for the largest TIMEOUT
//   next_ptr() : round-robin pointer advance, modulo the configured requester count
package complex_mult_arbiter_pkg;

    localparam int MAX_REQ     = 8;
    localparam int REQ_IDX_W   = $clog2(MAX_REQ);
    localparam int MAX_TIMEOUT = 65536;
    localparam int WDOG_W      = $clog2(MAX_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    // Pointer to the requester after idx, wrapping at num_req.
    function automatic logic [REQ_IDX_W-1:0] next_ptr(input logic [REQ_IDX_W-1:0] idx,
                                                      input int num_req);
        if (int'(idx) >= num_req - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/complex_mult_arbiter_if.sv
// Bus bundle between the arbiter, its requesters and the shared multiplier.
//   Requester side : req_val/req_ready with packed operand slices (slice i = requester i),
//                    rsp_val/rsp_ready with a shared result bus and rsp_err.
//   Multiplier side: mult_op_val/mult_op_ready with operands,
//                    mult_res_val/mult_res_ready with results.
// Modports: slave = the arbiter, master = the environment (requesters plus multiplier).
//
// Handshake rule for every val/ready pair on this bus: a transfer happens on the rising
// clock edge where both val and ready are high; a sender keeps val and its data stable
// until that edge, and ready never depends on a transfer already having happened.
interface complex_mult_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_val;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op_1_re;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op_1_im;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op_2_re;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op_2_im;
    logic [NUM_REQ-1:0]            rsp_val;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [2*DATA_WIDTH-1:0]       rsp_result_re;
    logic [2*DATA_WIDTH-1:0]       rsp_result_im;
    logic                          rsp_err;

    logic                          mult_op_val;
    logic                          mult_op_ready;
    logic [DATA_WIDTH-1:0]         mult_op_1_re;
    logic [DATA_WIDTH-1:0]         mult_op_1_im;
    logic [DATA_WIDTH-1:0]         mult_op_2_re;
    logic [DATA_WIDTH-1:0]         mult_op_2_im;
    logic                          mult_res_val;
    logic                          mult_res_ready;
    logic [2*DATA_WIDTH-1:0]       mult_result_re;
    logic [2*DATA_WIDTH-1:0]       mult_result_im;

    modport slave (
        input  req_val, req_op_1_re, req_op_1_im, req_op_2_re, req_op_2_im, rsp_ready,
        output req_ready, rsp_val, rsp_result_re, rsp_result_im, rsp_err,
        output mult_op_val, mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im,
        input  mult_op_ready,
        input  mult_res_val, mult_result_re, mult_result_im,
        output mult_res_ready
    );

    modport master (
        output req_val, req_op_1_re, req_op_1_im, req_op_2_re, req_op_2_im, rsp_ready,
        input  req_ready, rsp_val, rsp_result_re, rsp_result_im, rsp_err,
        input  mult_op_val, mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im,
        output mult_op_ready,
        output mult_res_val, mult_result_re, mult_result_im,
        input  mult_res_ready
    );

endinterface

// File: rtl/complex_mult_arbiter_rr_priority_picker.sv
// Round-robin priority picker (combinational).
//   req_val   in  NUM_REQ    requests
//   rr_ptr    in  REQ_IDX_W  highest-priority requester this round
//   grant     out NUM_REQ    one-hot: first request at or after rr_ptr, wrapping
//   grant_idx out REQ_IDX_W  index of the granted requester (0 when none)
//   grant_any out 1          some request was granted
module rr_priority_picker
    import complex_mult_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]   req_val,
    input  logic [REQ_IDX_W-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [REQ_IDX_W-1:0] grant_idx,
    output logic                 grant_any
);

    // Walk the requesters in priority order (offset k from rr_ptr). The inner loop keeps
    // every vector index a loop constant; only the matching position is considered.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int pos;
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && (i == pos) && req_val[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = REQ_IDX_W'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/complex_mult_arbiter.sv
// Shares one complex multiplier among NUM_REQ requesters, one job in flight at a time.
//   clk        in   clock
//   rstn       in   asynchronous reset, active low
//   sw_rst     in   synchronous soft reset, active high
//   bus        slave modport of complex_mult_arbiter_if (requester and multiplier handshakes)
//   busy       out  a job is held (state != IDLE)
//   dbg_state  out  current FSM state
// Flow: IDLE (round-robin accept) -> ISSUE (send operands) -> WAIT_RES (collect result or
// time out after TIMEOUT cycles) -> DELIVER (hand result to the granted requester) -> IDLE.
module complex_mult_arbiter
    import complex_mult_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    complex_mult_arbiter_if.slave   bus,
    output logic                    busy,
    output state_t                  dbg_state
);

    localparam int DW = DATA_WIDTH;

    state_t                state, state_nxt;
    logic [REQ_IDX_W-1:0]  rr_ptr;
    logic [REQ_IDX_W-1:0]  g;
    logic [DW-1:0]         op_1_re, op_1_im, op_2_re, op_2_im;
    logic [2*DW-1:0]       res_re, res_im;
    logic                  err;
    logic [WDOG_W-1:0]     wdog;

    logic [NUM_REQ-1:0]    grant;
    logic [REQ_IDX_W-1:0]  grant_idx;
    logic                  grant_any;
    logic [DW-1:0]         sel_1_re, sel_1_im, sel_2_re, sel_2_im;
    logic                  rsp_ready_g;
    logic [NUM_REQ-1:0]    rsp_val_int;
    logic                  wdog_expired;
    logic                  in_reset;

    // Outputs are forced to 0 while either reset is asserted, so no handshake can
    // complete in a cycle whose state update is about to be discarded by sw_rst.
    assign in_reset     = !rstn || sw_rst;
    assign wdog_expired = (wdog == WDOG_W'(TIMEOUT - 1));

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_val   (bus.req_val),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Operand slices of the requester currently picked.
    always_comb begin
        sel_1_re = '0;
        sel_1_im = '0;
        sel_2_re = '0;
        sel_2_im = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_1_re = bus.req_op_1_re[i*DW +: DW];
                sel_1_im = bus.req_op_1_im[i*DW +: DW];
                sel_2_re = bus.req_op_2_re[i*DW +: DW];
                sel_2_im = bus.req_op_2_im[i*DW +: DW];
            end
        end
    end

    // Per-requester view of the registered grant index g.
    always_comb begin
        rsp_ready_g = 1'b0;
        rsp_val_int = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g == REQ_IDX_W'(i)) begin
                rsp_ready_g    = bus.rsp_ready[i];
                rsp_val_int[i] = (state == DELIVER);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (grant_any)                          state_nxt = ISSUE;
            ISSUE:    if (bus.mult_op_ready)                  state_nxt = WAIT_RES;
            WAIT_RES: if (bus.mult_res_val || wdog_expired)   state_nxt = DELIVER;
            DELIVER:  if (rsp_ready_g)                        state_nxt = IDLE;
            default:                                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            g       <= '0;
            op_1_re <= '0;
            op_1_im <= '0;
            op_2_re <= '0;
            op_2_im <= '0;
            res_re  <= '0;
            res_im  <= '0;
            err     <= 1'b0;
            wdog    <= '0;
        end else if (sw_rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            g       <= '0;
            op_1_re <= '0;
            op_1_im <= '0;
            op_2_re <= '0;
            op_2_im <= '0;
            res_re  <= '0;
            res_im  <= '0;
            err     <= 1'b0;
            wdog    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        g       <= grant_idx;
                        op_1_re <= sel_1_re;
                        op_1_im <= sel_1_im;
                        op_2_re <= sel_2_re;
                        op_2_im <= sel_2_im;
                    end
                end
                ISSUE: begin
                    if (bus.mult_op_ready) begin
                        wdog <= '0;
                    end
                end
                WAIT_RES: begin
                    // A real result wins over a watchdog expiring in the same cycle.
                    if (bus.mult_res_val) begin
                        res_re <= bus.mult_result_re;
                        res_im <= bus.mult_result_im;
                        err    <= 1'b0;
                    end else if (wdog_expired) begin
                        res_re <= '0;
                        res_im <= '0;
                        err    <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DELIVER: begin
                    if (rsp_ready_g) begin
                        rr_ptr <= next_ptr(g, NUM_REQ);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready      = (!in_reset && state == IDLE) ? grant : '0;
    assign bus.rsp_val        = in_reset ? '0 : rsp_val_int;
    assign bus.rsp_result_re  = in_reset ? '0 : res_re;
    assign bus.rsp_result_im  = in_reset ? '0 : res_im;
    assign bus.rsp_err        = !in_reset && err;

    assign bus.mult_op_val    = !in_reset && (state == ISSUE);
    assign bus.mult_op_1_re   = in_reset ? '0 : op_1_re;
    assign bus.mult_op_1_im   = in_reset ? '0 : op_1_im;
    assign bus.mult_op_2_re   = in_reset ? '0 : op_2_re;
    assign bus.mult_op_2_im   = in_reset ? '0 : op_2_im;
    assign bus.mult_res_ready = !in_reset && (state == WAIT_RES);

    assign busy      = !in_reset && (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Directed bench for complex_mult_arbiter: the bench plays the requesters and the shared
// multiplier; expected responses are queued when a job is driven and checked on delivery.
module tb_complex_mult_arbiter;
    import complex_mult_arbiter_pkg::*;

    localparam int DW      = 8;
    localparam int NR      = 4;
    localparam int TIMEOUT = 64;
    localparam int EW      = 1 + 3 + 4*DW;

    logic   clk = 1'b0;
    logic   rstn;
    logic   sw_rst;
    logic   busy;
    state_t dbg_state;

    complex_mult_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    complex_mult_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_rst    (sw_rst),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / global time limit ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL time_limit: simulation did not finish within 300000 time units");
        $fatal(1, "time limit");
    end

    // ---------------- bench state ----------------
    int              checks = 0;
    int              errors = 0;
    logic [EW-1:0]   exp_q[$];
    logic [DW-1:0]   o1re[NR], o1im[NR], o2re[NR], o2im[NR];
    int              req_cnt[NR];
    logic [NR-1:0]   drop;
    logic            acc_seen, res_seen;
    int              acc_idx;
    int              wait_cnt;
    int              mult_lat;
    logic            mult_hang;

    function automatic logic [4*DW-1:0] cmul(input logic [DW-1:0] a, b, c, d);
        logic signed [2*DW-1:0] sa, sb, sc, sd, re, im;
        sa = {{DW{a[DW-1]}}, a};
        sb = {{DW{b[DW-1]}}, b};
        sc = {{DW{c[DW-1]}}, c};
        sd = {{DW{d[DW-1]}}, d};
        re = sa * sc - sb * sd;
        im = sa * sd + sb * sc;
        return {re, im};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- multiplier model ----------------
    initial begin : mult_model
        logic [DW-1:0]   a, b, c, d;
        logic [4*DW-1:0] r;
        logic            ok;
        bus.mult_op_ready  = 1'b1;
        bus.mult_res_val   = 1'b0;
        bus.mult_result_re = '0;
        bus.mult_result_im = '0;
        forever begin
            @(negedge clk);
            if (bus.mult_op_val && bus.mult_op_ready) begin
                a = bus.mult_op_1_re;
                b = bus.mult_op_1_im;
                c = bus.mult_op_2_re;
                d = bus.mult_op_2_im;
                @(posedge clk); #1;
                if (!mult_hang) begin
                    repeat (mult_lat) begin @(posedge clk); #1; end
                    r = cmul(a, b, c, d);
                    bus.mult_res_val   = 1'b1;
                    bus.mult_result_re = r[4*DW-1:2*DW];
                    bus.mult_result_im = r[2*DW-1:0];
                    ok = 1'b0;
                    for (int k = 0; k < 16 && !ok; k++) begin
                        @(negedge clk);
                        ok = bus.mult_res_ready;
                        @(posedge clk); #1;
                    end
                    bus.mult_res_val   = 1'b0;
                    bus.mult_result_re = '0;
                    bus.mult_result_im = '0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ops(input int i, input logic [DW-1:0] a, b, c, d);
        o1re[i] = a; o1im[i] = b; o2re[i] = c; o2im[i] = d;
        bus.req_op_1_re[i*DW +: DW] = a;
        bus.req_op_1_im[i*DW +: DW] = b;
        bus.req_op_2_re[i*DW +: DW] = c;
        bus.req_op_2_im[i*DW +: DW] = d;
    endtask

    task automatic rand_ops(input int i);
        set_ops(i, DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)),
                   DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
    endtask

    task automatic push_exp(input int i, input logic e);
        if (e) exp_q.push_back({1'b1, 3'(i), {4*DW{1'b0}}});
        else   exp_q.push_back({1'b0, 3'(i), cmul(o1re[i], o1im[i], o2re[i], o2im[i])});
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Scoreboard/monitor sampling at the falling edge.
    task automatic observe();
        logic [EW-1:0] item;
        acc_seen = 1'b0;
        res_seen = 1'b0;
        if (bus.req_ready != '0) check("req_ready_onehot", $countones(bus.req_ready), 1);
        for (int i = 0; i < NR; i++) begin
            if (bus.req_val[i] && bus.req_ready[i]) begin
                acc_seen = 1'b1;
                acc_idx  = i;
                if (req_cnt[i] > 0) req_cnt[i]--;
                if (req_cnt[i] == 0) drop[i] = 1'b1;
            end
        end
        if ((bus.rsp_val & bus.rsp_ready) != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(bus.rsp_val), 0);
            end else begin
                item = exp_q.pop_front();
                check("rsp_onehot", $countones(bus.rsp_val), 1);
                check("rsp_idx", onehot_idx(bus.rsp_val), 64'(item[EW-2 -: 3]));
                check("rsp_re", bus.rsp_result_re, item[4*DW-1:2*DW]);
                check("rsp_im", bus.rsp_result_im, item[2*DW-1:0]);
                check("rsp_err", bus.rsp_err, item[EW-1]);
            end
        end
        if (bus.mult_res_val && bus.mult_res_ready) res_seen = 1'b1;
        if (dbg_state == WAIT_RES) wait_cnt++;
    endtask

    // One clock: sample at negedge, then drive at posedge+1.
    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk); #1;
        bus.req_val = bus.req_val & ~drop;
        drop = '0;
    endtask

    task automatic wait_empty(input int bound, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin cycle(); n++; end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_state(input state_t s, input int bound, input string tag);
        int n;
        n = 0;
        while (dbg_state != s && n < bound) begin cycle(); n++; end
        check(tag, 64'(dbg_state), 64'(s));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_rsp_val"}, bus.rsp_val, 0);
        check({tag, "_rsp_re"}, bus.rsp_result_re, 0);
        check({tag, "_rsp_err"}, bus.rsp_err, 0);
        check({tag, "_op_val"}, bus.mult_op_val, 0);
        check({tag, "_op_1_re"}, bus.mult_op_1_re, 0);
        check({tag, "_res_ready"}, bus.mult_res_ready, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [4*DW-1:0] r;
        rstn            = 1'b0;
        sw_rst          = 1'b0;
        bus.req_val     = '0;
        bus.rsp_ready   = '1;
        bus.req_op_1_re = '0;
        bus.req_op_1_im = '0;
        bus.req_op_2_re = '0;
        bus.req_op_2_im = '0;
        drop            = '0;
        wait_cnt        = 0;
        mult_lat        = 0;
        mult_hang       = 1'b0;
        for (int i = 0; i < NR; i++) req_cnt[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("por");
        rstn = 1'b1;
        cycle();

        // Async reset in the middle of WAIT_RES drops the job.
        mult_hang = 1'b1;
        set_ops(0, 8'd7, 8'd1, 8'd2, 8'd9);
        req_cnt[0] = 1; bus.req_val[0] = 1'b1;
        wait_state(WAIT_RES, 20, "t1_reach_wait");
        repeat (3) cycle();
        rstn = 1'b0;
        #1;
        check_all_zero("t1_rst");
        repeat (2) cycle();
        rstn = 1'b1;
        mult_hang = 1'b0;
        repeat (20) cycle();
        check("t1_after_busy", busy, 0);
        check("t1_after_state", 64'(dbg_state), 64'(IDLE));

        // Single job on requester 0: (3+4j)*(2+5j) = -14+23j.
        set_ops(0, 8'd3, 8'd4, 8'd2, 8'd5);
        push_exp(0, 1'b0);
        req_cnt[0] = 1; bus.req_val[0] = 1'b1;
        for (int n = 0; n < 20 && !acc_seen; n++) cycle();
        check("t2_accept", acc_seen, 1);
        check("t2_op_val_lat", bus.mult_op_val, 1);
        check("t2_op_1_re", bus.mult_op_1_re, 3);
        check("t2_op_1_im", bus.mult_op_1_im, 4);
        check("t2_op_2_re", bus.mult_op_2_re, 2);
        check("t2_op_2_im", bus.mult_op_2_im, 5);
        for (int n = 0; n < 20 && !res_seen; n++) cycle();
        check("t2_res_seen", res_seen, 1);
        check("t2_rsp_val_lat", bus.rsp_val, 4'b0001);
        check("t2_re", bus.rsp_result_re, 16'hFFF2);
        check("t2_im", bus.rsp_result_im, 16'd23);
        check("t2_err", bus.rsp_err, 0);
        wait_empty(20, "t2_done");

        // Soft reset in IDLE brings the pointer back to 0.
        sw_rst = 1'b1;
        cycle();
        sw_rst = 1'b0;
        check("sw_idle_state", 64'(dbg_state), 64'(IDLE));

        // All four held: grants 0,1,2,3,0.
        mult_lat = 1;
        for (int i = 0; i < NR; i++) rand_ops(i);
        req_cnt[0] = 2; req_cnt[1] = 1; req_cnt[2] = 1; req_cnt[3] = 1;
        push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(2, 1'b0);
        push_exp(3, 1'b0); push_exp(0, 1'b0);
        bus.req_val = 4'b1111;
        wait_empty(300, "t3_done");
        check("t3_req_val_drained", bus.req_val, 0);

        // Requester 1 repeats while requester 2 joins mid-job: order 1,2,1.
        mult_lat = 3;
        rand_ops(1); rand_ops(2);
        req_cnt[1] = 2; push_exp(1, 1'b0);
        bus.req_val[1] = 1'b1;
        for (int n = 0; n < 20 && !acc_seen; n++) cycle();
        check("t4_first_accept", acc_idx, 1);
        req_cnt[2] = 1; bus.req_val[2] = 1'b1;
        push_exp(2, 1'b0); push_exp(1, 1'b0);
        wait_empty(300, "t4_done");

        // Multiplier silent: timeout error response, then a normal job.
        mult_hang = 1'b1;
        rand_ops(3);
        req_cnt[3] = 1; push_exp(3, 1'b1);
        wait_cnt = 0;
        bus.req_val[3] = 1'b1;
        wait_empty(300, "t5_timeout_done");
        check("t5_wait_cycles", wait_cnt, TIMEOUT);
        mult_hang = 1'b0;
        mult_lat  = 0;
        rand_ops(0);
        req_cnt[0] = 1; push_exp(0, 1'b0);
        bus.req_val[0] = 1'b1;
        wait_empty(100, "t5_recover_done");

        // Granted requester stalls; other rsp_ready bits are ignored; sw_rst recovers.
        bus.rsp_ready = 4'b1011;
        set_ops(2, 8'h81, 8'h7F, 8'hC0, 8'h35);
        r = cmul(o1re[2], o1im[2], o2re[2], o2im[2]);
        req_cnt[2] = 1; push_exp(2, 1'b0);
        bus.req_val[2] = 1'b1;
        wait_state(DELIVER, 50, "t6_reach_deliver");
        rand_ops(0); rand_ops(1);
        req_cnt[0] = 1; req_cnt[1] = 1;
        bus.req_val[0] = 1'b1; bus.req_val[1] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("t6_hold_rsp_val", bus.rsp_val, 4'b0100);
            check("t6_hold_re", bus.rsp_result_re, r[4*DW-1:2*DW]);
            check("t6_hold_im", bus.rsp_result_im, r[2*DW-1:0]);
            check("t6_hold_err", bus.rsp_err, 0);
            check("t6_no_req_ready", bus.req_ready, 0);
        end
        sw_rst = 1'b1;
        #1;
        check("t6_sw_rsp_val", bus.rsp_val, 0);
        check("t6_sw_req_ready", bus.req_ready, 0);
        check("t6_sw_busy", busy, 0);
        cycle();
        sw_rst = 1'b0;
        check("t6_sw_state", 64'(dbg_state), 64'(IDLE));
        exp_q.delete();
        bus.rsp_ready = 4'b1111;
        push_exp(0, 1'b0); push_exp(1, 1'b0);
        wait_empty(100, "t6_after_sw");

        repeat (5) cycle();
        check("final_state", 64'(dbg_state), 64'(IDLE));
        check("final_req_val", bus.req_val, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
